riscv_fetch: RTL and testbench
==============================

# riscv_fetch

Instruction-fetch stage of the pipelined RV32I core. It holds the fetch PC, issues one-outstanding-request reads to instruction memory, and loads the IF/ID pipeline register that drives the decode stage's instruction and PC inputs. It absorbs decode stalls, flushes and execute-stage redirects without dropping or duplicating instructions, including redirects that arrive while a memory read is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000, fetch address of the first instruction after reset
- i_clk  in  1  core clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_imem_addr  out  `XLEN  fetch address (pc_f with [1:0] forced to 0)
- o_imem_req  out  1  read request; address stable while high and un-acked
- i_imem_rdata  in  32  instruction word, valid only with i_imem_ack
- i_imem_ack  in  1  response for current request; may arrive in the same cycle as req or any later cycle
- i_stall_d  in  1  decode stalled: IF/ID must hold, fetch must not advance
- i_flush_d  in  1  load bubble into IF/ID
- i_pc_src_e  in  1  redirect request from execute (taken branch/jump)
- i_pc_target_e  in  `XLEN  redirect target
- o_instr_d  out  32  IF/ID instruction
- o_pc_d  out  `XLEN  IF/ID PC
- o_pc_plus4_d  out  `XLEN  IF/ID PC+4
- o_valid_d  out  1  IF/ID holds a real instruction

## Operation
- State: pc_f, FSM {IDLE, WAIT, HOLD}, hold buffer (instr, pc), redirect-pending flag + saved target.
- IDLE: entered only by reset; no request; next cycle -> WAIT (redirect in IDLE: pc_f <= target).
- WAIT: o_imem_req=1, o_imem_addr=pc_f. Without ack: stay.
- Ack in WAIT, "accepted" = !i_stall_d && !i_flush_d:
  - No redirect now or pending, accepted: IF/ID <= {rdata, pc_f, pc_f+4, valid=1}; pc_f <= pc_f+4; stay WAIT.
  - No redirect, not accepted: capture {rdata, pc_f} into hold buffer; -> HOLD; req low.
  - i_pc_src_e this cycle: discard rdata; pc_f <= i_pc_target_e; clear pending; stay WAIT.
  - Pending set (no new redirect): discard rdata; pc_f <= saved target; clear pending.
- i_pc_src_e in WAIT without ack: save target, set pending (later redirect overwrites target); address unchanged until ack.
- HOLD: req low. If i_pc_src_e: drop buffer, pc_f <= target, -> WAIT. Else if accepted: IF/ID <= buffer (valid=1), pc_f <= buffer pc+4, -> WAIT. Else stay.
- IF/ID update priority: i_flush_d (bubble: instr 32'h0000_0013, valid 0, PCs 0) > i_stall_d (hold) > load from fetch > no delivery (bubble when !i_stall_d and nothing delivered).
- A flush without redirect does not lose the in-flight instruction: it is treated as not accepted (held/buffered).
- Arithmetic: pc+4 modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0). Target bits [1:0] ignored.

## Timing
- Reset (async, immediate): pc_f=RESET_PC, state IDLE, pending=0, o_imem_req=0, o_imem_addr=RESET_PC, o_instr_d=32'h0000_0013, o_pc_d=0, o_pc_plus4_d=0, o_valid_d=0.
- First request: cycle 1 after reset release.
- Latency: ack in cycle N -> o_instr_d/o_valid_d valid from cycle N+1.
- Throughput: 1 instr/cycle when ack is same-cycle as req; request for pc+4 is presented the cycle after ack.
- Redirect penalty: target requested the cycle after redirect (or after the outstanding ack, whichever later).
- Reset mid-request: request abandoned; a late ack after reset release but before the first request is ignored (ack ignored outside WAIT).
- HOLD -> IF/ID transfer occurs on the first cycle with accept; next request the following cycle.

## Test plan
- Zero-wait memory, RESET_PC=0x0: after reset, addr 0x0,0x4,0x8 on consecutive cycles; o_pc_d 0x0,0x4,0x8 with matching instr, o_valid_d=1 from cycle 2.
- Ack delayed 3 cycles: o_imem_addr held 0x0 with req=1 for 3 cycles; one instruction delivered, no duplicates.
- i_stall_d for 4 cycles on ack of 0x8: HOLD entered, req=0, IF/ID unchanged; on release 0x8 loaded once, next addr 0xC.
- i_pc_src_e target 0x100 while 0x10 outstanding (ack 2 cycles later): 0x10 word discarded, next addr 0x100, o_valid_d=0 meanwhile.
- i_pc_src_e + i_flush_d same cycle as ack of 0x20: IF/ID bubble (0x00000013, valid 0), next addr = target.
- RESET_PC=0xFFFF_FFFC: second fetch addr 0x0; assert i_rst mid-WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding reads to
// instruction memory and loads the IF/ID register feeding decode.
//
//   state | meaning
//   IDLE  | just out of reset, no request issued yet
//   WAIT  | request for pc_f outstanding, waiting for ack
//   HOLD  | fetched word parked in hold buffer until decode accepts it
module riscv_fetch #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [XLEN-1:0] o_imem_addr,
    output logic            o_imem_req,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_imem_ack,
    input  logic            i_stall_d,
    input  logic            i_flush_d,
    input  logic            i_pc_src_e,
    input  logic [XLEN-1:0] i_pc_target_e,
    output logic [31:0]     o_instr_d,
    output logic [XLEN-1:0] o_pc_d,
    output logic [XLEN-1:0] o_pc_plus4_d,
    output logic            o_valid_d
);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_AL = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_f;
    logic            pend;
    logic [XLEN-1:0] pend_tgt;
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] hold_pc;

    logic            accept;
    logic            deliver;
    logic [31:0]     del_instr;
    logic [XLEN-1:0] del_pc;
    logic [XLEN-1:0] tgt;

    assign accept      = !i_stall_d && !i_flush_d;
    assign tgt         = {i_pc_target_e[XLEN-1:2], 2'b00};
    assign o_imem_req  = (state == WAIT);
    assign o_imem_addr = pc_f;

    // A word reaches IF/ID only when it is neither stale nor overridden by a redirect.
    always_comb begin
        deliver   = 1'b0;
        del_instr = hold_instr;
        del_pc    = hold_pc;
        if (state == WAIT && i_imem_ack && !i_pc_src_e && !pend && accept) begin
            deliver   = 1'b1;
            del_instr = i_imem_rdata;
            del_pc    = pc_f;
        end else if (state == HOLD && !i_pc_src_e && accept) begin
            deliver = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pc_f         <= RESET_AL;
            pend         <= 1'b0;
            pend_tgt     <= '0;
            hold_instr   <= NOP;
            hold_pc      <= '0;
            o_instr_d    <= NOP;
            o_pc_d       <= '0;
            o_pc_plus4_d <= '0;
            o_valid_d    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_pc_src_e) pc_f <= tgt;
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_imem_ack) begin
                        if (i_pc_src_e) begin
                            pc_f <= tgt;
                            pend <= 1'b0;
                        end else if (pend) begin
                            pc_f <= pend_tgt;
                            pend <= 1'b0;
                        end else if (accept) begin
                            pc_f <= pc_f + FOUR;
                        end else begin
                            hold_instr <= i_imem_rdata;
                            hold_pc    <= pc_f;
                            state      <= HOLD;
                        end
                    end else if (i_pc_src_e) begin
                        // Address must stay stable until the ack, so remember the target.
                        pend     <= 1'b1;
                        pend_tgt <= tgt;
                    end
                end
                HOLD: begin
                    if (i_pc_src_e) begin
                        pc_f  <= tgt;
                        state <= WAIT;
                    end else if (accept) begin
                        pc_f  <= hold_pc + FOUR;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase

            if (i_flush_d || (!i_stall_d && !deliver)) begin
                o_instr_d    <= NOP;
                o_pc_d       <= '0;
                o_pc_plus4_d <= '0;
                o_valid_d    <= 1'b0;
            end else if (!i_stall_d) begin
                o_instr_d    <= del_instr;
                o_pc_d       <= del_pc;
                o_pc_plus4_d <= del_pc + FOUR;
                o_valid_d    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: memory model returns a word derived from the
// address; stimulus changes and checks happen on the falling clock edge.
module tb_riscv_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // DUT with RESET_PC = 0
    logic        rst, req, ack, stall, flush, pc_src, valid;
    logic        ack_auto, ack_man;
    logic [31:0] addr, rdata, target, instr, pc_d, pc_p4;

    assign ack   = ack_auto ? req : ack_man;
    assign rdata = instr_of(addr);

    riscv_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_addr(addr), .o_imem_req(req),
        .i_imem_rdata(rdata), .i_imem_ack(ack),
        .i_stall_d(stall), .i_flush_d(flush),
        .i_pc_src_e(pc_src), .i_pc_target_e(target),
        .o_instr_d(instr), .o_pc_d(pc_d), .o_pc_plus4_d(pc_p4), .o_valid_d(valid)
    );

    // DUT with RESET_PC at the top of the address space
    logic        rst2, req2, ack2, valid2, ack2_auto, ack2_man, zero;
    logic [31:0] addr2, rdata2, instr2, pc_d2, pc_p42, zero_w;

    assign ack2   = ack2_auto ? req2 : ack2_man;
    assign rdata2 = instr_of(addr2);
    assign zero   = 1'b0;
    assign zero_w = 32'h0;

    riscv_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .i_clk(clk), .i_rst(rst2),
        .o_imem_addr(addr2), .o_imem_req(req2),
        .i_imem_rdata(rdata2), .i_imem_ack(ack2),
        .i_stall_d(zero), .i_flush_d(zero),
        .i_pc_src_e(zero), .i_pc_target_e(zero_w),
        .o_instr_d(instr2), .o_pc_d(pc_d2), .o_pc_plus4_d(pc_p42), .o_valid_d(valid2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        stall = 0; flush = 0; pc_src = 0; target = 0;
        ack_auto = 0; ack_man = 0; ack2_auto = 0; ack2_man = 0;
        #1;
        check("rst_req",   {31'b0, req},   0);
        check("rst_addr",  addr,           32'h0);
        check("rst_instr", instr,          NOP);
        check("rst_pc",    pc_d,           0);
        check("rst_pc4",   pc_p4,          0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst2_addr", addr2,          32'hFFFF_FFFC);

        // zero-wait streaming
        tick(); rst = 1'b0; ack_auto = 1;
        tick();
        check("s0_req",   {31'b0, req},   1);
        check("s0_addr",  addr,           32'h0);
        check("s0_valid", {31'b0, valid}, 0);
        tick();
        check("s1_addr",  addr,           32'h4);
        check("s1_pc",    pc_d,           32'h0);
        check("s1_instr", instr,          instr_of(32'h0));
        check("s1_valid", {31'b0, valid}, 1);
        tick();
        check("s2_addr",  addr,           32'h8);
        check("s2_pc",    pc_d,           32'h4);
        check("s2_pc4",   pc_p4,          32'h8);
        check("s2_instr", instr,          instr_of(32'h4));

        // stall on ack of 0x8 for four cycles
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", {31'b0, req},   0);
            check("stall_pc",  pc_d,           32'h4);
            check("stall_vld", {31'b0, valid}, 1);
        end
        stall = 0;
        tick();
        check("rel_pc",    pc_d,           32'h8);
        check("rel_instr", instr,          instr_of(32'h8));
        check("rel_addr",  addr,           32'hC);
        check("rel_req",   {31'b0, req},   1);
        ack_auto = 0;

        // ack delayed three cycles on 0xC
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dly_addr",  addr,           32'hC);
            check("dly_req",   {31'b0, req},   1);
            check("dly_valid", {31'b0, valid}, 0);
        end
        ack_man = 1;
        tick(); ack_man = 0;
        check("dly_pc",    pc_d,           32'hC);
        check("dly_instr", instr,          instr_of(32'hC));
        check("dly_vld1",  {31'b0, valid}, 1);
        check("dly_next",  addr,           32'h10);
        tick();
        check("dly_nodup", {31'b0, valid}, 0);

        // redirect while 0x10 outstanding, ack two cycles later
        pc_src = 1; target = 32'h100;
        tick(); pc_src = 0; target = 0;
        check("pend_addr",  addr,           32'h10);
        check("pend_valid", {31'b0, valid}, 0);
        tick(); ack_man = 1;
        tick(); ack_man = 0;
        check("pend_tgt",   addr,           32'h100);
        check("pend_req",   {31'b0, req},   1);
        check("pend_drop",  {31'b0, valid}, 0);
        ack_auto = 1;
        tick();
        check("tgt_pc",    pc_d,  32'h100);
        check("tgt_instr", instr, instr_of(32'h100));

        // redirect to 0x20, then redirect + flush on ack of 0x20
        pc_src = 1; target = 32'h20;
        tick();
        check("r20_addr",  addr,           32'h20);
        check("r20_valid", {31'b0, valid}, 0);
        pc_src = 1; flush = 1; target = 32'h203;
        tick(); pc_src = 0; target = 0;
        check("rf_instr", instr,          NOP);
        check("rf_valid", {31'b0, valid}, 0);
        check("rf_pc",    pc_d,           0);
        check("rf_addr",  addr,           32'h200);

        // flush alone must not lose the word fetched from 0x200
        tick(); flush = 0;
        check("fl_req",   {31'b0, req},   0);
        check("fl_valid", {31'b0, valid}, 0);
        tick();
        check("fl_pc",    pc_d,           32'h200);
        check("fl_pc4",   pc_p4,          32'h204);
        check("fl_instr", instr,          instr_of(32'h200));
        check("fl_addr",  addr,           32'h204);
        ack_auto = 0;

        // wrap-around from RESET_PC = 0xFFFF_FFFC
        tick(); rst2 = 0; ack2_auto = 1;
        tick();
        check("w_addr0", addr2,          32'hFFFF_FFFC);
        check("w_req0",  {31'b0, req2},  1);
        tick(); ack2_auto = 0;
        check("w_addr1", addr2,          32'h0);
        check("w_pc",    pc_d2,          32'hFFFF_FFFC);
        check("w_pc4",   pc_p42,         32'h0);
        check("w_valid", {31'b0, valid2}, 1);

        // asynchronous reset in the middle of a request
        #2 rst2 = 1;
        #1;
        check("ar_req",   {31'b0, req2},   0);
        check("ar_addr",  addr2,           32'hFFFF_FFFC);
        check("ar_instr", instr2,          NOP);
        check("ar_pc",    pc_d2,           0);
        check("ar_valid", {31'b0, valid2}, 0);

        // stale ack before the first request is ignored
        tick(); rst2 = 0; ack2_man = 1;
        tick(); ack2_man = 0;
        check("late_addr",  addr2,           32'hFFFF_FFFC);
        check("late_req",   {31'b0, req2},   1);
        check("late_valid", {31'b0, valid2}, 0);
        ack2_man = 1;
        tick(); ack2_man = 0;
        check("late_pc",   pc_d2,           32'hFFFF_FFFC);
        check("late_vld",  {31'b0, valid2}, 1);
        check("late_next", addr2,           32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
